// File: rtl/synaptic_current_integrator_if.sv
// ============================================================================
// Module   : synaptic_current_integrator_if
// Purpose  : Start/spike/weight request and current-result bundle for the integrator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface synaptic_current_integrator_if #(
    parameter int N     = 7,
    parameter int W_W   = 16,
    parameter int ACC_W = 20
);
    logic                   start;
    logic [N-1:0]           spikes;
    logic [N*N*W_W-1:0]     weights_flat;
    logic                   busy;
    logic                   done;
    logic [N*ACC_W-1:0]     currents_flat;

    modport master (
        output start, spikes, weights_flat,
        input  busy, done, currents_flat
    );

    modport slave (
        input  start, spikes, weights_flat,
        output busy, done, currents_flat
    );
endinterface

`default_nettype wire

// File: rtl/synaptic_current_integrator.sv
// ============================================================================
// Module   : synaptic_current_integrator
// Purpose  : Serial MAC of spike-gated Hebbian weights into N saturating currents.
// Revision : 1.0
// ============================================================================
`default_nettype none

module synaptic_current_integrator #(
    parameter int N     = 7,
    parameter int W_W   = 16,
    parameter int ACC_W = 20
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    synaptic_current_integrator_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);
    localparam logic [ACC_W-1:0] c_acc_max  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_acc_min  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
    logic [N-1:0]       spk_q, spk_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   shadow_q [N];
    logic [ACC_W-1:0]   shadow_d [N];
    logic [ACC_W-1:0]   cur_q    [N];
    logic [ACC_W-1:0]   cur_d    [N];
    logic [W_W-1:0]     w_arr    [N][N];

    logic [W_W-1:0]     w_sel;
    logic [ACC_W:0]     w_ext, acc_ext, sum;
    logic [ACC_W-1:0]   sum_sat, acc_step;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign w_arr[gi][gj] = bus.weights_flat[((gi*N)+gj)*W_W +: W_W];
        end
        assign bus.currents_flat[gi*ACC_W +: ACC_W] = cur_q[gi];
    end

    assign bus.busy = (state_q == ACCUM);
    assign bus.done = done_q;

    // One extra bit of headroom detects overflow; clamp instead of wrapping.
    always_comb begin
        w_sel   = w_arr[i_q][j_q];
        w_ext   = {{(ACC_W+1-W_W){w_sel[W_W-1]}}, w_sel};
        acc_ext = {acc_q[ACC_W-1], acc_q};
        sum     = acc_ext + w_ext;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sum_sat = sum[ACC_W] ? c_acc_min : c_acc_max;
        end else begin
            sum_sat = sum[ACC_W-1:0];
        end
        acc_step = (spk_q[j_q] && (i_q != j_q)) ? sum_sat : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        spk_d    = spk_q;
        acc_d    = acc_q;
        shadow_d = shadow_q;
        cur_d    = cur_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    spk_d   = bus.spikes;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                if (j_q == c_last_idx) begin
                    shadow_d[i_q] = acc_step;
                    acc_d         = '0;
                    j_d           = '0;
                    if (i_q == c_last_idx) begin
                        // Publish every row at once; last row comes straight from the adder.
                        cur_d        = shadow_q;
                        cur_d[N-1]   = acc_step;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                        i_d          = '0;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_step;
                    j_d   = j_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            spk_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
                cur_q[k]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            spk_q    <= spk_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            cur_q    <= cur_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_synaptic_current_integrator.sv
// ============================================================================
// Module   : tb_synaptic_current_integrator
// Purpose  : Directed self-checking bench for synaptic_current_integrator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_synaptic_current_integrator;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    synaptic_current_integrator_if #(.N(7), .W_W(16), .ACC_W(20)) bus1();
    synaptic_current_integrator_if #(.N(7), .W_W(16), .ACC_W(16)) bus2();

    // The narrow-accumulator instance shares start and spikes with the main one.
    assign bus2.start  = bus1.start;
    assign bus2.spikes = bus1.spikes;

    synaptic_current_integrator #(.N(7), .W_W(16), .ACC_W(20)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    synaptic_current_integrator #(.N(7), .W_W(16), .ACC_W(16)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] cur1(int k);
        return bus1.currents_flat[k*20 +: 20];
    endfunction

    function automatic logic [15:0] cur2(int k);
        return bus2.currents_flat[k*16 +: 16];
    endfunction

    task automatic set_w1(int i, int j, int v);
        bus1.weights_flat[((i*7)+j)*16 +: 16] = 16'(v);
    endtask

    task automatic set_w2(int i, int j, int v);
        bus2.weights_flat[((i*7)+j)*16 +: 16] = 16'(v);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                set_w1(i, j, i*10 + j);
    endtask

    // Pulse start for one cycle, return the edge count after acceptance at which done appears.
    task automatic run_pass(output int cyc);
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus1.done) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus1.busy); end
        checks++;
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus1.done); end
        checks++;
        if (bus1.currents_flat !== '0) begin errors++; $display("FAIL reset_currents: got %h expected 0", bus1.currents_flat); end
        checks++;
        if (bus2.currents_flat !== '0 || bus2.busy !== 1'b0) begin
            errors++; $display("FAIL reset_dut2: got cur=%h busy=%b expected 0/0", bus2.currents_flat, bus2.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        int exp_i[7] = '{2, 22, 20, 62, 82, 102, 122};
        logic [19:0] held;
        fill_pattern();
        bus1.spikes = 7'b0000101;
        run_pass(cyc);
        checks++;
        if (cyc !== 49) begin errors++; $display("FAIL basic_latency: got %0d expected 49", cyc); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cur1(k) !== 20'(exp_i[k])) begin
                errors++; $display("FAIL basic_I%0d: got %0d expected %0d", k, $signed(cur1(k)), exp_i[k]);
            end
        end
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", bus1.busy); end
        held = cur1(3);
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", bus1.done); end
        repeat (3) @(negedge clk);
        checks++;
        if (cur1(3) !== 20'd62 || held !== 20'd62) begin
            errors++; $display("FAIL basic_hold: got %0d expected 62", cur1(3));
        end
    endtask

    task automatic test_diagonal();
        int cyc;
        bus1.weights_flat = '0;
        set_w1(0, 0, 100);
        set_w1(1, 0, -5);
        bus1.spikes = 7'b0000001;
        run_pass(cyc);
        checks++;
        if (cyc !== 49) begin errors++; $display("FAIL diag_latency: got %0d expected 49", cyc); end
        checks++;
        if (cur1(0) !== 20'd0) begin errors++; $display("FAIL diag_I0: got %0d expected 0", $signed(cur1(0))); end
        checks++;
        if (cur1(1) !== 20'hFFFFB) begin errors++; $display("FAIL diag_I1: got %0d expected -5", $signed(cur1(1))); end
        for (int k = 2; k < 7; k++) begin
            checks++;
            if (cur1(k) !== 20'd0) begin errors++; $display("FAIL diag_I%0d: got %0d expected 0", k, $signed(cur1(k))); end
        end
    endtask

    task automatic test_saturation();
        int cyc;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++) begin
                set_w2(i, j, (i == j) ? 0 : 20000);
                set_w1(i, j, (i == j) ? 0 : 20000);
            end
        bus1.spikes = 7'b1111111;
        run_pass(cyc);
        checks++;
        if (cyc !== 49) begin errors++; $display("FAIL sat_latency: got %0d expected 49", cyc); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cur2(k) !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_I%0d: got %0d expected 32767", k, $signed(cur2(k))); end
        end
        checks++;
        if (cur1(3) !== 20'd120000) begin errors++; $display("FAIL sat_wide_I3: got %0d expected 120000", $signed(cur1(3))); end
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                set_w2(i, j, -20000);
        run_pass(cyc);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cur2(k) !== 16'h8000) begin errors++; $display("FAIL sat_neg_I%0d: got %0d expected -32768", k, $signed(cur2(k))); end
        end
    endtask

    task automatic test_back_to_back();
        int n_done, first, second, bad_busy, c;
        fill_pattern();
        bus1.spikes = 7'b0000101;
        n_done = 0; first = -1; second = -1; bad_busy = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        for (c = 0; c <= 120; c++) begin
            @(negedge clk);
            if (bus1.busy === bus1.done) bad_busy++;
            if (bus1.done === 1'b1) begin
                n_done++;
                if (n_done == 1) first = c; else if (n_done == 2) second = c;
            end
        end
        bus1.start = 1'b0;
        checks++;
        if (n_done !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n_done); end
        checks++;
        if (first !== 49 || second !== 99) begin errors++; $display("FAIL b2b_edges: got %0d,%0d expected 49,99", first, second); end
        checks++;
        if (bad_busy !== 0) begin errors++; $display("FAIL b2b_busy: got %0d busy/done conflicts expected 0", bad_busy); end
        c = 0;
        while (bus1.done !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        checks++;
        if (bus1.done !== 1'b1 || cur1(1) !== 20'd22) begin
            errors++; $display("FAIL b2b_tail: got done=%b I1=%0d expected 1/22", bus1.done, $signed(cur1(1)));
        end
        // A start pulse mid-pass must neither queue nor restart.
        n_done = 0; first = -1;
        @(negedge clk);
        bus1.start = 1'b1;
        for (c = 0; c <= 120; c++) begin
            @(negedge clk);
            if (c == 0) bus1.start = 1'b0;
            if (c == 10) bus1.start = 1'b1;
            if (c == 11) bus1.start = 1'b0;
            if (bus1.done === 1'b1) begin n_done++; if (n_done == 1) first = c; end
        end
        checks++;
        if (n_done !== 1 || first !== 49) begin errors++; $display("FAIL ignore_start: got %0d dones first=%0d expected 1 at 49", n_done, first); end
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL ignore_start_busy: got %b expected 0", bus1.busy); end
    endtask

    task automatic test_reset_mid_pass();
        int cyc, c, saw_done;
        fill_pattern();
        bus1.spikes = 7'b0000101;
        run_pass(cyc);
        checks++;
        if (cur1(1) !== 20'd22) begin errors++; $display("FAIL rst_pass1_I1: got %0d expected 22", $signed(cur1(1))); end
        bus1.spikes = 7'b0000010;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (c = 1; c <= 20; c++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus1.busy); end
        checks++;
        if (bus1.currents_flat !== '0) begin errors++; $display("FAIL rst_mid_currents: got %h expected 0", bus1.currents_flat); end
        saw_done = 0;
        repeat (3) begin @(negedge clk); if (bus1.done !== 1'b0) saw_done++; end
        reset_n = 1'b1;
        repeat (60) begin @(negedge clk); if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) saw_done++; end
        checks++;
        if (saw_done !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", saw_done); end
        run_pass(cyc);
        checks++;
        if (cyc !== 49) begin errors++; $display("FAIL rst_after_latency: got %0d expected 49", cyc); end
        checks++;
        if (cur1(0) !== 20'd1 || cur1(1) !== 20'd0 || cur1(2) !== 20'd21 || cur1(6) !== 20'd61) begin
            errors++; $display("FAIL rst_after_result: got %0d,%0d,%0d,%0d expected 1,0,21,61",
                               cur1(0), cur1(1), cur1(2), cur1(6));
        end
    endtask

    task automatic test_live_inputs();
        int c;
        fill_pattern();
        bus1.spikes = 7'b0000101;
        @(negedge clk);
        bus1.start = 1'b1;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) bus1.start = 1'b0;
            if (c == 5) bus1.spikes = 7'b1111111;
            if (c == 30) set_w1(6, 0, 1000);
            if (bus1.done === 1'b1) break;
        end
        checks++;
        if (c !== 49) begin errors++; $display("FAIL live_latency: got %0d expected 49", c); end
        checks++;
        if (cur1(0) !== 20'd2 || cur1(1) !== 20'd22 || cur1(5) !== 20'd102) begin
            errors++; $display("FAIL live_spike_snapshot: got %0d,%0d,%0d expected 2,22,102", cur1(0), cur1(1), cur1(5));
        end
        checks++;
        if (cur1(6) !== 20'd1062) begin errors++; $display("FAIL live_weight: got %0d expected 1062", cur1(6)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus1.start = 1'b0;
        bus1.spikes = '0;
        bus1.weights_flat = '0;
        bus2.weights_flat = '0;
        test_reset();
        test_basic();
        test_diagonal();
        test_saturation();
        test_back_to_back();
        test_reset_mid_pass();
        test_live_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
